// File: rtl/ram_fifo_ctrl.sv
// FIFO controller wrapping a single-port RAM with registered read.
// Pops take two cycles (address, then capture); pushes take one and yield to pops.
module ram_fifo_ctrl #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned AW    = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   output logic             push_ready,
   input  logic             pop,
   output logic             pop_ready,
   output logic [WIDTH-1:0] pop_data,
   output logic             pop_valid,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count,
   output logic             err_ovf,
   output logic             err_unf,
   output logic [AW-1:0]    ram_addr,
   output logic [WIDTH-1:0] ram_data_in,
   output logic             ram_we,
   input  logic [WIDTH-1:0] ram_data_out
);

   localparam int unsigned DEPTH = 2**AW;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RD   = 1'b1;

   logic [0:0]    state;
   logic [0:0]    state_nxt;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_acc;
   logic          pop_acc;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);

   // Handshakes, RAM port steering and next state
   always_comb begin
      state_nxt   = state;
      pop_ready   = 1'b0;
      push_ready  = 1'b0;
      pop_acc     = 1'b0;
      push_acc    = 1'b0;
      ram_we      = 1'b0;
      ram_addr    = rd_ptr;
      ram_data_in = push_data;

      pop_ready  = (state == IDLE) && !empty && !clear;
      pop_acc    = pop && pop_ready;
      push_ready = (state == IDLE) && !full && !clear && !pop_acc;
      push_acc   = push && push_ready;

      if (push_acc) begin
         ram_we   = 1'b1;
         ram_addr = wr_ptr;
      end

      case (state)
         IDLE: if (pop_acc) state_nxt = RD;
         RD:   state_nxt = IDLE;
      endcase

      if (clear) state_nxt = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Pointers, occupancy, capture and sticky error flags
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         pop_data  <= '0;
         pop_valid <= 1'b0;
         err_ovf   <= 1'b0;
         err_unf   <= 1'b0;
      end else if (clear) begin
         // pop_data deliberately kept; an in-flight read is dropped
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         pop_valid <= 1'b0;
         err_ovf   <= 1'b0;
         err_unf   <= 1'b0;
      end else begin
         pop_valid <= (state == RD);
         if (state == RD) pop_data <= ram_data_out;
         if (push_acc) begin
            wr_ptr <= wr_ptr + AW'(1);
            count  <= count + (AW+1)'(1);
         end
         if (pop_acc) begin
            rd_ptr <= rd_ptr + AW'(1);
            count  <= count - (AW+1)'(1);
         end
         if (push && full && (state == IDLE)) err_ovf <= 1'b1;
         if (pop && empty && (state == IDLE)) err_unf <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural registered-read RAM
// and a reference FIFO feeding an expected-data scoreboard.
module tb_ram_fifo_ctrl;

   logic       clk;
   logic       rst;
   logic       clear;
   logic       push;
   logic [7:0] push_data;
   logic       push_ready;
   logic       pop;
   logic       pop_ready;
   logic [7:0] pop_data;
   logic       pop_valid;
   logic       full;
   logic       empty;
   logic [3:0] count;
   logic       err_ovf;
   logic       err_unf;
   logic [2:0] ram_addr;
   logic [7:0] ram_data_in;
   logic       ram_we;
   logic [7:0] ram_data_out;

   logic [7:0] mem [8];
   logic [7:0] model_q [$];
   logic [7:0] exp_q [$];
   logic [2:0] wr_m;
   logic [2:0] rd_m;
   int         cnt_m;
   int         vectors = 0;
   int         miscompares = 0;

   ram_fifo_ctrl #(.WIDTH(8), .AW(3)) dut (
      .clk          (clk),
      .rst          (rst),
      .clear        (clear),
      .push         (push),
      .push_data    (push_data),
      .push_ready   (push_ready),
      .pop          (pop),
      .pop_ready    (pop_ready),
      .pop_data     (pop_data),
      .pop_valid    (pop_valid),
      .full         (full),
      .empty        (empty),
      .count        (count),
      .err_ovf      (err_ovf),
      .err_unf      (err_unf),
      .ram_addr     (ram_addr),
      .ram_data_in  (ram_data_in),
      .ram_we       (ram_we),
      .ram_data_out (ram_data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port RAM, read data registered one cycle after the address
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_data_in;
      ram_data_out <= mem[ram_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [7:0] d);
      push      = 1'b1;
      push_data = d;
      #1;
      chk("push_ready", 32'(push_ready), 32'd1);
      chk("push_we", 32'(ram_we), 32'd1);
      chk("push_addr", 32'(ram_addr), 32'(wr_m));
      chk("push_wdata", 32'(ram_data_in), 32'(d));
      model_q.push_back(d);
      cyc();
      wr_m  = wr_m + 3'd1;
      cnt_m = cnt_m + 1;
      push  = 1'b0;
   endtask

   task automatic pop_one();
      logic [7:0] e;
      pop = 1'b1;
      #1;
      chk("pop_ready", 32'(pop_ready), 32'd1);
      chk("pop_we", 32'(ram_we), 32'd0);
      chk("pop_addr", 32'(ram_addr), 32'(rd_m));
      exp_q.push_back(model_q.pop_front());
      cyc();
      rd_m  = rd_m + 3'd1;
      cnt_m = cnt_m - 1;
      pop   = 1'b0;
      #1;
      chk("rd_valid_low", 32'(pop_valid), 32'd0);
      chk("rd_pop_ready", 32'(pop_ready), 32'd0);
      cyc();
      e = exp_q.pop_front();
      chk("pop_valid", 32'(pop_valid), 32'd1);
      chk("pop_data", 32'(pop_data), 32'(e));
   endtask

   task automatic model_reset();
      wr_m  = 3'd0;
      rd_m  = 3'd0;
      cnt_m = 0;
      model_q.delete();
      exp_q.delete();
   endtask

   initial begin
      rst       = 1'b1;
      clear     = 1'b0;
      push      = 1'b0;
      pop       = 1'b0;
      push_data = 8'h00;
      model_reset();
      repeat (2) cyc();
      rst = 1'b0;
      #1;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_pop_valid", 32'(pop_valid), 32'd0);
      chk("rst_pop_data", 32'(pop_data), 32'd0);
      chk("rst_err_ovf", 32'(err_ovf), 32'd0);
      chk("rst_err_unf", 32'(err_unf), 32'd0);
      chk("rst_we", 32'(ram_we), 32'd0);
      chk("rst_addr", 32'(ram_addr), 32'd0);

      // Three pushes then three pops
      push_one(8'h12);
      push_one(8'h34);
      push_one(8'h56);
      chk("fill3_count", 32'(count), 32'd3);
      chk("fill3_empty", 32'(empty), 32'd0);
      repeat (3) pop_one();
      chk("drain3_count", 32'(count), 32'd0);
      chk("drain3_empty", 32'(empty), 32'd1);
      cyc();
      chk("valid_pulse_end", 32'(pop_valid), 32'd0);
      chk("pop_data_hold", 32'(pop_data), 32'h56);

      // Flush pointers back to zero
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      #1;
      model_reset();
      chk("clr_count", 32'(count), 32'd0);
      chk("clr_addr", 32'(ram_addr), 32'd0);

      // Fill to full, then overflow attempt
      for (int i = 0; i < 8; i++) push_one(8'(8'hA0 + i));
      chk("full_flag", 32'(full), 32'd1);
      chk("full_count", 32'(count), 32'd8);
      push      = 1'b1;
      push_data = 8'hFF;
      #1;
      chk("ovf_push_ready", 32'(push_ready), 32'd0);
      chk("ovf_we", 32'(ram_we), 32'd0);
      cyc();
      push = 1'b0;
      chk("ovf_err", 32'(err_ovf), 32'd1);
      chk("ovf_count", 32'(count), 32'd8);

      // Partial drain, wrapped refill, full drain
      repeat (3) pop_one();
      push_one(8'hB0);
      push_one(8'hB1);
      push_one(8'hB2);
      chk("wrap_count", 32'(count), 32'd8);
      repeat (8) pop_one();
      chk("wrap_drain_count", 32'(count), 32'd0);
      chk("wrap_drain_empty", 32'(empty), 32'd1);
      chk("ovf_sticky", 32'(err_ovf), 32'd1);

      // Simultaneous push and pop: pop wins the RAM port
      push_one(8'hC0);
      push_one(8'hC1);
      push      = 1'b1;
      push_data = 8'hC2;
      pop       = 1'b1;
      #1;
      chk("both_push_ready", 32'(push_ready), 32'd0);
      chk("both_pop_ready", 32'(pop_ready), 32'd1);
      chk("both_we", 32'(ram_we), 32'd0);
      chk("both_addr", 32'(ram_addr), 32'(rd_m));
      exp_q.push_back(model_q.pop_front());
      cyc();
      rd_m  = rd_m + 3'd1;
      cnt_m = cnt_m - 1;
      push  = 1'b0;
      pop   = 1'b0;
      #1;
      chk("both_count", 32'(count), 32'(cnt_m));
      cyc();
      chk("both_valid", 32'(pop_valid), 32'd1);
      chk("both_data", 32'(pop_data), 32'(exp_q.pop_front()));
      pop_one();

      // Underflow
      pop = 1'b1;
      #1;
      chk("unf_pop_ready", 32'(pop_ready), 32'd0);
      cyc();
      pop = 1'b0;
      #1;
      chk("unf_err", 32'(err_unf), 32'd1);
      chk("unf_count", 32'(count), 32'd0);
      chk("unf_idle", 32'(push_ready), 32'd1);

      // Reset during RD aborts the read
      push_one(8'hD0);
      pop = 1'b1;
      #1;
      chk("abort_pop_ready", 32'(pop_ready), 32'd1);
      cyc();
      pop = 1'b0;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      #1;
      model_reset();
      chk("abort_rst_valid", 32'(pop_valid), 32'd0);
      chk("abort_rst_data", 32'(pop_data), 32'd0);
      chk("abort_rst_count", 32'(count), 32'd0);
      chk("abort_rst_empty", 32'(empty), 32'd1);
      chk("abort_rst_full", 32'(full), 32'd0);
      chk("abort_rst_ovf", 32'(err_ovf), 32'd0);
      chk("abort_rst_unf", 32'(err_unf), 32'd0);
      chk("abort_rst_we", 32'(ram_we), 32'd0);
      chk("abort_rst_addr", 32'(ram_addr), 32'd0);
      cyc();
      chk("abort_rst_valid2", 32'(pop_valid), 32'd0);

      // Clear during RD aborts the read but keeps pop_data
      pop = 1'b1;
      cyc();
      pop = 1'b0;
      chk("pre_clr_unf", 32'(err_unf), 32'd1);
      push_one(8'hE0);
      push_one(8'hE1);
      pop_one();
      pop = 1'b1;
      #1;
      chk("clr_abort_pop_ready", 32'(pop_ready), 32'd1);
      cyc();
      pop   = 1'b0;
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      #1;
      model_reset();
      chk("clr_abort_valid", 32'(pop_valid), 32'd0);
      chk("clr_abort_data", 32'(pop_data), 32'hE0);
      chk("clr_abort_count", 32'(count), 32'd0);
      chk("clr_abort_empty", 32'(empty), 32'd1);
      chk("clr_abort_unf", 32'(err_unf), 32'd0);
      chk("clr_abort_addr", 32'(ram_addr), 32'd0);
      chk("clr_abort_idle", 32'(push_ready), 32'd1);
      cyc();
      chk("clr_abort_valid2", 32'(pop_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
